program_loader: RTL and testbench

- Writer side of the CPU's 16x8 program memory. The CPU's memory path only reads; this block fills that memory.
- Accepts a framed byte stream (length, data, checksum) over a valid/ready handshake and writes it into an internal 16x8 RAM.
- Holds the CPU in clear while loading and releases it on a good frame.
- Exposes the same read port the CPU's MAR/memory path already uses (addr, low_o_en, tri-state data_out), so it replaces the ROM on the bus.

---
 rtl/program_loader_if.sv | 12 +
 rtl/program_loader.sv | 99 +++++++++
 tb/tb_program_loader.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_if.sv
// Byte-stream handshake into the program loader: the source drives data/valid and the loader
// answers with ready.
interface program_loader_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/program_loader.sv
// Writer side of the CPU program memory: loads a (length, data, checksum) frame into a small RAM,
// holds the CPU in clear until a good frame lands, and serves the CPU's tri-state read port.
module program_loader #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     low_clr,
    program_loader_if.slave          in_if,
    input  logic                     reload,
    output logic                     cpu_clr,
    output logic                     load_done,
    output logic                     load_err,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic                     low_o_en,
    output tri   [WIDTH-1:0]         data_out
);
    localparam int unsigned AddrW = $clog2(DEPTH);
    localparam logic [WIDTH-1:0] MaxLen = WIDTH'(DEPTH);

    typedef enum logic [2:0] {StLen, StData, StCsum, StDone, StErr} state_e;

    state_e           state_q;
    logic [AddrW-1:0] wr_ptr_q;
    logic [AddrW:0]   len_q;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] ram_q [DEPTH];
    logic             cpu_clr_q;
    logic             load_done_q;
    logic             load_err_q;
    logic             accept;
    logic             last_data;
    logic             len_ok;

    assign in_if.in_ready = (state_q == StLen || state_q == StData || state_q == StCsum) && !reload;
    assign accept         = in_if.in_valid && in_if.in_ready;
    // Compared one bit wider so a full-depth frame ends after the write at the top address.
    assign last_data      = ({1'b0, wr_ptr_q} + (AddrW + 1)'(1)) == len_q;
    assign len_ok         = (in_if.in_data != '0) && (in_if.in_data <= MaxLen);

    always_ff @(posedge clk or negedge low_clr) begin
        if (!low_clr) begin
            state_q     <= StLen;
            wr_ptr_q    <= '0;
            len_q       <= '0;
            sum_q       <= '0;
            cpu_clr_q   <= 1'b1;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) ram_q[i] <= '0;
        end else if (reload) begin
            state_q     <= StLen;
            wr_ptr_q    <= '0;
            len_q       <= '0;
            sum_q       <= '0;
            cpu_clr_q   <= 1'b1;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) ram_q[i] <= '0;
        end else if (accept) begin
            unique case (state_q)
                StLen: begin
                    if (len_ok) begin
                        len_q    <= in_if.in_data[AddrW:0];
                        sum_q    <= in_if.in_data;
                        wr_ptr_q <= '0;
                        state_q  <= StData;
                    end else begin
                        state_q    <= StErr;
                        load_err_q <= 1'b1;
                    end
                end
                StData: begin
                    ram_q[wr_ptr_q] <= in_if.in_data;
                    sum_q           <= sum_q + in_if.in_data;
                    wr_ptr_q        <= wr_ptr_q + 1'b1;
                    if (last_data) state_q <= StCsum;
                end
                StCsum: begin
                    if (in_if.in_data == sum_q) begin
                        state_q     <= StDone;
                        cpu_clr_q   <= 1'b0;
                        load_done_q <= 1'b1;
                    end else begin
                        state_q    <= StErr;
                        load_err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cpu_clr   = cpu_clr_q;
    assign load_done = load_done_q;
    assign load_err  = load_err_q;

    assign data_out = low_o_en ? {WIDTH{1'bz}} : ram_q[addr];
endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: a frame-level model (list of accepted bytes) predicts every output on
// each falling edge, and directed frames add hand-computed literal checks.
module tb_program_loader;
    logic       clk;
    logic       low_clr;
    logic       reload;
    logic       cpu_clr;
    logic       load_done;
    logic       load_err;
    logic [3:0] addr;
    logic       low_o_en;
    tri   [7:0] data_bus;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    program_loader_if #(.WIDTH(8)) in_if ();

    program_loader #(.DEPTH(16), .WIDTH(8)) dut (
        .clk       (clk),
        .low_clr   (low_clr),
        .in_if     (in_if),
        .reload    (reload),
        .cpu_clr   (cpu_clr),
        .load_done (load_done),
        .load_err  (load_err),
        .addr      (addr),
        .low_o_en  (low_o_en),
        .data_out  (data_bus)
    );

    // Bench keeps the bus at a known pattern whenever the loader should be released from it.
    assign data_bus = low_o_en ? 8'h5A : 8'bz;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: the frame is just the list of bytes accepted since the last reset/reload.
    logic [7:0] frame[$];

    function automatic int model_status();  // 0 loading, 1 done, 2 error
        int l;
        int s;
        if (frame.size() == 0) return 0;
        l = int'(frame[0]);
        if (l == 0 || l > 16) return 2;
        if (frame.size() < l + 2) return 0;
        s = 0;
        for (int i = 0; i <= l; i++) s += int'(frame[i]);
        return ((s % 256) == int'(frame[l + 1])) ? 1 : 2;
    endfunction

    function automatic logic [7:0] model_mem(int a);
        int l;
        if (frame.size() == 0) return 8'h00;
        l = int'(frame[0]);
        if (l == 0 || l > 16) return 8'h00;
        if (a < l && a + 1 < frame.size()) return frame[a + 1];
        return 8'h00;
    endfunction

    always @(posedge clk or negedge low_clr) begin
        if (!low_clr) frame.delete();
        else if (reload) frame.delete();
        else if (in_if.in_valid && model_status() == 0) frame.push_back(in_if.in_data);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        int st;
        if (chk_en) begin
            st = model_status();
            check("in_ready", {31'b0, in_if.in_ready}, {31'b0, (!reload && st == 0)});
            check("cpu_clr", {31'b0, cpu_clr}, {31'b0, (st != 1)});
            check("load_done", {31'b0, load_done}, {31'b0, (st == 1)});
            check("load_err", {31'b0, load_err}, {31'b0, (st == 2)});
            check("data_out", {24'b0, data_bus}, {24'b0, low_o_en ? 8'h5A : model_mem(int'(addr))});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Idle gaps put junk on in_data with valid low; only the handshaked byte may land.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit rdy;
        for (int i = 0; i < gap; i++) begin
            in_if.in_valid = 1'b0;
            in_if.in_data  = 8'($urandom);
            tick();
        end
        in_if.in_valid = 1'b1;
        in_if.in_data  = b;
        rdy = 1'b0;
        for (int i = 0; i < 20 && !rdy; i++) begin
            @(negedge clk);
            rdy = in_if.in_ready;
            tick();
        end
        check("handshake", {31'b0, rdy}, 32'd1);
        in_if.in_valid = 1'b0;
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        tick();
        reload = 1'b0;
    endtask

    task automatic read_lit(input string name, input logic [3:0] a, input logic [7:0] exp);
        addr     = a;
        low_o_en = 1'b0;
        @(negedge clk);
        check(name, {24'b0, data_bus}, {24'b0, exp});
        tick();
    endtask

    task automatic sweep();
        for (int a = 0; a < 16; a++) begin
            addr     = 4'(a);
            low_o_en = 1'b0;
            tick();
            low_o_en = 1'b1;
            tick();
        end
        low_o_en = 1'b0;
    endtask

    initial begin
        logic [7:0] s;
        low_clr        = 1'b1;
        reload         = 1'b0;
        in_if.in_valid = 1'b0;
        in_if.in_data  = 8'h00;
        addr           = 4'h0;
        low_o_en       = 1'b0;

        // Reset and idle
        #3 low_clr = 1'b0;
        chk_en = 1'b1;
        sweep();
        low_clr = 1'b1;
        tick();
        @(negedge clk);
        check("idle_cpu_clr", {31'b0, cpu_clr}, 32'd1);
        check("idle_ready", {31'b0, in_if.in_ready}, 32'd1);
        check("idle_done", {31'b0, load_done}, 32'd0);
        tick();
        sweep();

        // Good frame: 03+1E+2F+E0 = 0x130 -> checksum 30
        send_byte(8'h03, 0);
        send_byte(8'h1E, 0);
        send_byte(8'h2F, 0);
        send_byte(8'hE0, 0);
        send_byte(8'h30, 0);
        @(negedge clk);
        check("good_done", {31'b0, load_done}, 32'd1);
        check("good_cpu_clr", {31'b0, cpu_clr}, 32'd0);
        check("good_ready", {31'b0, in_if.in_ready}, 32'd0);
        tick();
        read_lit("good_a0", 4'd0, 8'h1E);
        read_lit("good_a1", 4'd1, 8'h2F);
        read_lit("good_a2", 4'd2, 8'hE0);
        read_lit("good_a3", 4'd3, 8'h00);
        addr     = 4'd0;
        low_o_en = 1'b1;
        @(negedge clk);
        check("good_hiz", {24'b0, data_bus}, 32'h5A);
        tick();
        // Junk offered while done must be ignored
        in_if.in_valid = 1'b1;
        in_if.in_data  = 8'h66;
        repeat (3) tick();
        in_if.in_valid = 1'b0;
        sweep();

        // Same data with checksum 2F is one short of the true sum
        pulse_reload();
        send_byte(8'h03, 0);
        send_byte(8'h1E, 0);
        send_byte(8'h2F, 0);
        send_byte(8'hE0, 0);
        send_byte(8'h2F, 0);
        @(negedge clk);
        check("off_by_one_err", {31'b0, load_err}, 32'd1);
        tick();

        // Bad checksum: 02+10+20 = 32, send 33
        pulse_reload();
        send_byte(8'h02, 0);
        send_byte(8'h10, 0);
        send_byte(8'h20, 0);
        send_byte(8'h33, 0);
        @(negedge clk);
        check("bad_err", {31'b0, load_err}, 32'd1);
        check("bad_cpu_clr", {31'b0, cpu_clr}, 32'd1);
        check("bad_done", {31'b0, load_done}, 32'd0);
        tick();
        read_lit("bad_keeps_a1", 4'd1, 8'h20);
        pulse_reload();
        @(negedge clk);
        check("reload_err", {31'b0, load_err}, 32'd0);
        tick();
        read_lit("reload_a0", 4'd0, 8'h00);
        sweep();

        // Length bounds
        send_byte(8'h00, 0);
        @(negedge clk);
        check("len0_err", {31'b0, load_err}, 32'd1);
        tick();
        pulse_reload();
        send_byte(8'h11, 0);
        @(negedge clk);
        check("len17_err", {31'b0, load_err}, 32'd1);
        tick();
        pulse_reload();
        s = 8'h10;
        send_byte(8'h10, 0);
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(8'h10 + i), 0);
            s = s + 8'(8'h10 + i);
        end
        send_byte(s, 0);  // 0x88
        @(negedge clk);
        check("len16_done", {31'b0, load_done}, 32'd1);
        tick();
        read_lit("len16_a15", 4'd15, 8'h1F);
        read_lit("len16_a0", 4'd0, 8'h10);

        // Backpressure with random gaps: 04+AA+BB+CC+DD = 0x312 -> 12
        pulse_reload();
        send_byte(8'h04, int'($urandom_range(0, 3)));
        send_byte(8'hAA, int'($urandom_range(0, 3)));
        send_byte(8'hBB, int'($urandom_range(0, 3)));
        send_byte(8'hCC, int'($urandom_range(0, 3)));
        send_byte(8'hDD, int'($urandom_range(0, 3)));
        send_byte(8'h12, int'($urandom_range(0, 3)));
        @(negedge clk);
        check("bp_done", {31'b0, load_done}, 32'd1);
        tick();
        read_lit("bp_a3", 4'd3, 8'hDD);
        sweep();

        // Reload and a valid byte on the same edge mid-DATA
        pulse_reload();
        send_byte(8'h05, 0);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        reload         = 1'b1;
        in_if.in_valid = 1'b1;
        in_if.in_data  = 8'h77;
        @(negedge clk);
        check("reload_blocks_ready", {31'b0, in_if.in_ready}, 32'd0);
        tick();
        reload         = 1'b0;
        in_if.in_valid = 1'b0;
        send_byte(8'h01, 1);
        send_byte(8'h99, 0);
        send_byte(8'h9A, 0);
        @(negedge clk);
        check("restart_done", {31'b0, load_done}, 32'd1);
        tick();
        read_lit("restart_a0", 4'd0, 8'h99);
        read_lit("restart_a1", 4'd1, 8'h00);

        // Asynchronous reset while done, then mid-frame
        @(posedge clk);
        #2 low_clr = 1'b0;
        #1;
        check("async_cpu_clr", {31'b0, cpu_clr}, 32'd1);
        check("async_done", {31'b0, load_done}, 32'd0);
        tick();
        low_clr = 1'b1;
        tick();
        send_byte(8'h03, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        read_lit("midframe_a0", 4'd0, 8'h11);
        @(posedge clk);
        #2 low_clr = 1'b0;
        #1;
        check("async_ram_clr", {24'b0, data_bus}, 32'h00);
        tick();
        low_clr = 1'b1;
        sweep();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
